pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed-field inter-stage latches between IF/ID/EX/MEM/WB. It carries an opaque data payload and a control vector under a valid/ready handshake, with synchronous flush that guarantees a bubble (all control bits zero) and a saturating stall counter for performance debug. It sits between any two pipeline stages; an optional skid entry breaks the combinational ready path.

## Interface
- DATA_W, 64: payload width (ALU result, store data, rd, etc., concatenated by the instantiating stage).
- CTRL_W, 4: control vector width; bits are cleared whenever the output is not valid.
- CNT_W, 16: stall counter width.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries and the current input.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
- in_data  in  DATA_W  payload.
- in_ctrl  in  CTRL_W  control vector.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
- out_data  out  DATA_W  payload of head entry.
- out_ctrl  out  CTRL_W  control of head entry; all-zero when out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating.

## Operation
- One clock, single domain. Reset (reset_n=0, async assert, sync deassert by the system): out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0, skid entry empty, in_ready=1 one cycle after deassert is not required; in_ready=1 during and after reset.
- States: EMPTY (no entry), FULL (head entry valid), SKID (head + skid entry valid; only with PIPE_SKID_EN).
- EMPTY: in_valid → FULL, head ← input.
- FULL: out transfer && no in transfer → EMPTY; in transfer && out transfer → FULL with new head; in transfer && no out transfer → SKID (skid ← input) when skid enabled (impossible otherwise, in_ready=0).
- SKID: out transfer → FULL, head ← skid; in_ready=0, no input accepted.
- flush has priority over every transfer: next state EMPTY, any input offered in the flush cycle is dropped, stall_cnt unaffected except by its own rule.
- out_data retains last head value when out_valid=0; out_ctrl forced to zero whenever out_valid=0 (bubble guarantee for reg_write/mem_write style bits).
- stall_cnt increments by 1 per cycle with out_valid && !out_ready; saturates at 2^CNT_W−1; cleared only by reset.
- Ordering strictly FIFO; no entry duplicated or lost except by flush.

## Timing
- Latency: input accepted in cycle N appears at out_valid in cycle N+1.
- Throughput: one entry per cycle when out_ready stays high.
- Without skid: in_ready = !out_valid || out_ready (combinational from out_ready).
- With skid: in_ready = skid entry empty, driven directly from a flop; no combinational path from out_ready to in_ready.
- flush asserted in cycle N: out_valid=0 and out_ctrl=0 in cycle N+1.
- Reset asserted mid-transfer: all state cleared immediately, asynchronously.

## Configuration
- PIPE_SKID_EN defined: two-entry storage, SKID state exists, registered in_ready.
- Not defined: single entry, SKID unreachable and not synthesised, in_ready combinational as above.
- Handshake semantics, flush and stall_cnt identical in both builds.

## Structure
- Shared package pipe_pkg: state enum (EMPTY, FULL, SKID), control bit index constants (CTRL_MEM_READ=0, CTRL_MEM_WRITE=1, CTRL_REG_WRITE=2, CTRL_MEM_TO_REG=3), default widths.
- One sub-module: pipe_sat_counter (CNT_W parameter, inc enable, saturating) for stall_cnt.

## Test plan
- Reset: hold reset_n=0 with in_valid=1 → out_valid=0, out_ctrl=0, stall_cnt=0; release, send data=0x1234, ctrl=4'b0101 → appears next cycle.
- Streaming: 8 back-to-back entries 0..7, out_ready=1 → out_data 0..7 on consecutive cycles, no gaps.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → skid build accepts exactly 2 entries, in_ready=0 after; non-skid accepts 1; stall_cnt=3; order preserved on release.
- Flush: flush=1 while SKID with in_valid=1 → next cycle out_valid=0, out_ctrl=0, dropped entries never appear.
- Saturation: CNT_W=4, stall 20 cycles → stall_cnt=15 and holds.
- Random valid/ready 10k cycles vs reference FIFO model → no loss, no duplication, out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the parametrised pipeline stage register.
//   - pipe_state_t : occupancy state of a stage (EMPTY / FULL / SKID)
//   - CTRL_*       : bit positions inside the control vector carried by a stage
//   - DEFAULT_*    : default widths used by pipe_stage_reg
//   Optional feature macro: PIPE_SKID_EN (see pipe_stage_reg.sv).
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no entry held
    FULL  = 2'd1,  // head entry valid
    SKID  = 2'd2   // head + skid entry valid (skid build only)
  } pipe_state_t;

  // Control vector bit indices
  localparam int CTRL_MEM_READ   = 0;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_REG_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;

  // Default widths
  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_CTRL_W = 4;
  localparam int DEFAULT_CNT_W  = 16;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
//   One valid/ready hop of a pipeline: payload + control vector.
//   Ports of the interface:
//     valid  producer offers an entry
//     ready  consumer can accept; transfer when valid && ready
//     data   opaque payload (DATA_W bits)
//     ctrl   control vector (CTRL_W bits)
//   Modports:
//     master : producer side (drives valid/data/ctrl, samples ready)
//     slave  : consumer side (drives ready, samples valid/data/ctrl)
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 4
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid,
    output data,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    output ready
  );

endinterface : pipe_stage_reg_if

// File: rtl/pipe_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_sat_counter
//   Saturating up-counter used for stall accounting.
//   Ports:
//     clk      in   rising-edge clock
//     reset_n  in   asynchronous active-low reset (clears the count)
//     i_inc    in   add one this cycle (ignored once saturated)
//     o_count  out  current count, sticks at 2^CNT_W-1
// -----------------------------------------------------------------------------
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  // All ones means saturated; further increments are discarded.
  assign w_at_max = &r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule : pipe_sat_counter

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic inter-stage register: carries a payload and a control vector under
//   a valid/ready handshake, with synchronous flush (guaranteed bubble) and a
//   saturating stall counter.
//
//   Ports:
//     clk        in   rising-edge clock
//     reset_n    in   asynchronous active-low reset
//     flush      in   synchronous kill of held entries and the current input
//     up         pipe_stage_reg_if.slave  : upstream in_valid/in_ready/in_data/in_ctrl
//     dn         pipe_stage_reg_if.master : downstream out_valid/out_ready/out_data/out_ctrl
//     stall_cnt  out  cycles with out_valid && !out_ready (saturating)
//
//   Build option:
//     PIPE_SKID_EN  defined  -> two entries (head + skid), in_ready from a flop
//                   undefined-> single entry, in_ready = !out_valid || out_ready
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CTRL_W = DEFAULT_CTRL_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  pipe_stage_reg_if.slave   up,
  pipe_stage_reg_if.master  dn,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       r_state;
  pipe_state_t       w_state_next;

  logic [DATA_W-1:0] r_head_data;
  logic [CTRL_W-1:0] r_head_ctrl;

  logic              w_out_valid;
  logic              w_in_ready;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_head_load;
  logic [CTRL_W-1:0] w_out_ctrl;

  assign w_out_valid = (r_state != EMPTY);
  assign w_in_xfer   = up.valid && w_in_ready;
  assign w_out_xfer  = w_out_valid && dn.ready;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              r_in_ready;
  logic              w_skid_load;
  logic              w_head_from_skid;

  // Registered ready: the stage advertises space whenever the skid slot is
  // free, so out_ready never reaches in_ready combinationally.
  assign w_in_ready = r_in_ready;
`else
  // Single entry: space exists if empty or the head leaves this cycle.
  assign w_in_ready = !w_out_valid || dn.ready;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / load decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_head_load      = 1'b0;
`ifdef PIPE_SKID_EN
    w_skid_load      = 1'b0;
    w_head_from_skid = 1'b0;
`endif
    if (flush) begin
      // Flush beats every transfer; the input offered now is dropped.
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_state_next = FULL;
            w_head_load  = 1'b1;
          end
        end
        FULL: begin
          if (w_in_xfer && w_out_xfer) begin
            w_head_load = 1'b1;
          end else if (w_out_xfer) begin
            w_state_next = EMPTY;
`ifdef PIPE_SKID_EN
          end else if (w_in_xfer) begin
            w_state_next = SKID;
            w_skid_load  = 1'b1;
`endif
          end
        end
`ifdef PIPE_SKID_EN
        SKID: begin
          // in_ready is low here, so only the head can move.
          if (w_out_xfer) begin
            w_state_next     = FULL;
            w_head_from_skid = 1'b1;
          end
        end
`endif
        default: begin
          w_state_next = EMPTY;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and head entry
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= EMPTY;
      r_head_data <= '0;
      r_head_ctrl <= '0;
    end else begin
      r_state <= w_state_next;
      // Head is not cleared on flush: out_data keeps its last value while
      // out_ctrl is masked to zero by the output logic.
      if (w_head_load) begin
        r_head_data <= up.data;
        r_head_ctrl <= up.ctrl;
`ifdef PIPE_SKID_EN
      end else if (w_head_from_skid) begin
        r_head_data <= r_skid_data;
        r_head_ctrl <= r_skid_ctrl;
`endif
      end
    end
  end

`ifdef PIPE_SKID_EN
  // ---------------------------------------------------------------------------
  // Skid entry and registered in_ready
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
      r_in_ready  <= 1'b1;
    end else begin
      if (w_skid_load) begin
        r_skid_data <= up.data;
        r_skid_ctrl <= up.ctrl;
      end
      r_in_ready <= (w_state_next != SKID);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs: every control bit is gated by out_valid so a bubble can never
  // carry a stale reg_write / mem_write.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
      assign w_out_ctrl[gi] = r_head_ctrl[gi] & w_out_valid;
    end
  endgenerate

  assign up.ready = w_in_ready;
  assign dn.valid = w_out_valid;
  assign dn.data  = r_head_data;
  assign dn.ctrl  = w_out_ctrl;

  // ---------------------------------------------------------------------------
  // Stall accounting
  // ---------------------------------------------------------------------------
  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_out_valid && !dn.ready),
    .o_count (stall_cnt)
  );

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg (CNT_W=4) plus a short random
//   valid/ready/flush run against a FIFO reference model.
//   Works for both builds; PIPE_SKID_EN selects the expected capacity.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 4;
  localparam int CNT_W  = 4;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic             clk;
  logic             reset_n;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up_if ();
  pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn_if ();

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .up        (up_if.slave),
    .dn        (dn_if.master),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle: inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [67:0] q[$];
  int          acc;
  logic        in_x, out_x, fl;
  logic [31:0] seq;

  initial begin
    reset_n     = 1'b0;
    flush       = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 64'hDEAD;
    up_if.ctrl  = 4'hF;
    dn_if.ready = 1'b1;

    // ---------------- reset with in_valid held high ----------------
    step();
    step();
    check("rst_out_valid", 64'(dn_if.valid), 64'd0);
    check("rst_out_ctrl",  64'(dn_if.ctrl),  64'd0);
    check("rst_stall_cnt", 64'(stall_cnt),   64'd0);
    check("rst_in_ready",  64'(up_if.ready), 64'd1);
    up_if.valid = 1'b0;
    reset_n     = 1'b1;
    step();

    // ---------------- first entry: latency 1 ----------------
    up_if.valid = 1'b1;
    up_if.data  = 64'h1234;
    up_if.ctrl  = 4'b0101;
    step();
    $display("xfer first data=0x%0h ctrl=0x%0h", dn_if.data, dn_if.ctrl);
    check("first_valid", 64'(dn_if.valid), 64'd1);
    check("first_data",  dn_if.data,       64'h1234);
    check("first_ctrl",  64'(dn_if.ctrl),  64'h5);
    up_if.valid = 1'b0;
    step();
    check("bubble_valid",     64'(dn_if.valid), 64'd0);
    check("bubble_ctrl_zero", 64'(dn_if.ctrl),  64'd0);
    check("bubble_data_hold", dn_if.data,       64'h1234);

    // ---------------- streaming 0..7 ----------------
    for (int i = 0; i <= 8; i++) begin
      up_if.valid = (i < 8);
      up_if.data  = 64'(i);
      up_if.ctrl  = 4'(i);
      #1;
      if (i > 0) begin
        $display("xfer stream data=0x%0h ctrl=0x%0h", dn_if.data, dn_if.ctrl);
        check($sformatf("stream_valid_%0d", i - 1), 64'(dn_if.valid), 64'd1);
        check($sformatf("stream_data_%0d", i - 1),  dn_if.data,       64'(i - 1));
        check($sformatf("stream_ctrl_%0d", i - 1),  64'(dn_if.ctrl),  64'(i - 1));
      end
      step();
    end
    check("stream_drained", 64'(dn_if.valid), 64'd0);
    check("stream_no_stall", 64'(stall_cnt), 64'd0);

    // ---------------- backpressure: 4 offers, out_ready=0 ----------------
    dn_if.ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      up_if.valid = 1'b1;
      up_if.data  = 64'hA0 + 64'(acc);
      up_if.ctrl  = 4'(acc + 1);
      #1;
      if (up_if.ready) acc++;
      step();
    end
    up_if.valid = 1'b0;
    #1;
    check("bp_accepted",  64'(acc),         64'(CAP));
    check("bp_in_ready",  64'(up_if.ready), 64'd0);
    check("bp_stall_cnt", 64'(stall_cnt),   64'd3);
    check("bp_head_data", dn_if.data,       64'hA0);
    check("bp_head_ctrl", 64'(dn_if.ctrl),  64'h1);
    dn_if.ready = 1'b1;
    step();
`ifdef PIPE_SKID_EN
    check("bp_second_valid", 64'(dn_if.valid), 64'd1);
    check("bp_second_data",  dn_if.data,       64'hA1);
    check("bp_second_ctrl",  64'(dn_if.ctrl),  64'h2);
    step();
`endif
    check("bp_drained", 64'(dn_if.valid), 64'd0);
    check("bp_stall_hold", 64'(stall_cnt), 64'd3);

    // ---------------- flush while empty with input offered ----------------
    up_if.valid = 1'b1;
    up_if.data  = 64'hEE;
    up_if.ctrl  = 4'hF;
    flush       = 1'b1;
    step();
    flush       = 1'b0;
    up_if.valid = 1'b0;
    #1;
    check("flush_empty_valid", 64'(dn_if.valid), 64'd0);
    check("flush_empty_ctrl",  64'(dn_if.ctrl),  64'd0);
    step();
    check("flush_empty_none", 64'(dn_if.valid), 64'd0);

    // ---------------- flush at full occupancy ----------------
    dn_if.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      up_if.valid = 1'b1;
      up_if.data  = 64'hB0 + 64'(i);
      up_if.ctrl  = 4'hC;
      step();
    end
    up_if.data = 64'hCC;
    up_if.ctrl = 4'hF;
    flush      = 1'b1;
    step();
    flush       = 1'b0;
    up_if.valid = 1'b0;
    #1;
    check("flush_full_valid", 64'(dn_if.valid), 64'd0);
    check("flush_full_ctrl",  64'(dn_if.ctrl),  64'd0);
    check("flush_full_ready", 64'(up_if.ready), 64'd1);
    dn_if.ready = 1'b1;
    step();
    check("flush_full_none1", 64'(dn_if.valid), 64'd0);
    step();
    check("flush_full_none2", 64'(dn_if.valid), 64'd0);

    // ---------------- asynchronous reset while holding an entry ----------------
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 64'hD0;
    up_if.ctrl  = 4'h4;
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(dn_if.valid), 64'd0);
    check("arst_ctrl",  64'(dn_if.ctrl),  64'd0);
    check("arst_data",  dn_if.data,       64'd0);
    check("arst_stall", 64'(stall_cnt),   64'd0);
    check("arst_ready", 64'(up_if.ready), 64'd1);
    up_if.valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // ---------------- stall counter saturation (CNT_W=4) ----------------
    up_if.valid = 1'b1;
    up_if.data  = 64'h5A;
    up_if.ctrl  = 4'h3;
    dn_if.ready = 1'b0;
    step();
    up_if.valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14) check("sat_14", 64'(stall_cnt), 64'd14);
      if (k == 15) check("sat_15", 64'(stall_cnt), 64'd15);
      if (k == 20) check("sat_hold", 64'(stall_cnt), 64'd15);
    end
    check("sat_head_kept", dn_if.data, 64'h5A);
    dn_if.ready = 1'b1;
    step();
    check("sat_after_drain", 64'(stall_cnt), 64'd15);

    // ---------------- random valid/ready/flush vs FIFO model ----------------
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    q.delete();
    seq = 32'd0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      up_if.valid = ($urandom_range(0, 1) == 1);
      up_if.data  = {32'hC0DE0000, seq};
      up_if.ctrl  = 4'($urandom_range(0, 15));
      dn_if.ready = ($urandom_range(0, 3) != 0);
      fl          = ($urandom_range(0, 39) == 0);
      flush       = fl;
      #1;
      check($sformatf("rnd_valid_%0d", cyc), 64'(dn_if.valid), 64'(q.size() != 0));
`ifdef PIPE_SKID_EN
      check($sformatf("rnd_ready_%0d", cyc), 64'(up_if.ready), 64'(q.size() < 2));
`else
      check($sformatf("rnd_ready_%0d", cyc), 64'(up_if.ready), 64'(q.size() == 0 || dn_if.ready));
`endif
      if (q.size() != 0) begin
        check($sformatf("rnd_data_%0d", cyc), dn_if.data,      64'(q[0][63:0]));
        check($sformatf("rnd_ctrl_%0d", cyc), 64'(dn_if.ctrl), 64'(q[0][67:64]));
      end else begin
        check($sformatf("rnd_bubble_%0d", cyc), 64'(dn_if.ctrl), 64'd0);
      end
      in_x  = up_if.valid && up_if.ready;
      out_x = dn_if.valid && dn_if.ready;
      if (out_x && !fl) $display("xfer rnd data=0x%0h ctrl=0x%0h", dn_if.data, dn_if.ctrl);
      if (fl) begin
        q.delete();
      end else begin
        if (out_x && q.size() != 0) void'(q.pop_front());
        if (in_x) q.push_back({up_if.ctrl, up_if.data});
      end
      if (in_x) seq++;
      step();
    end
    flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_stage_reg
